// File: rtl/quad_and_gate_ctrl.sv
// quad_and_gate_ctrl: trigger-gating sequencer for an MC10H104-style quad AND.
// Opens a timed enable window on TRIG once armed, then latches which lanes fired.
//
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_cfg_wr/addr/data      config bus: 0=MASK 1=WINDOW 2=HOLDOFF 3=CTRL
//                           (CTRL bit1 DISARM, bit0 AUTO_REARM)
//   o_cfg_ack               one-cycle ack, the cycle after a write
//   i_arm, i_trig           arm request, trigger
//   i_and_in                registered gate outputs {D,C,B,A}
//   o_gate_out              enable legs {DIN2,CIN2,BIN2,AIN2}
//   o_hit, o_hit_valid      lanes seen in last window, update strobe
//   o_busy, o_state         OPEN/HOLDOFF flag, FSM state
//   o_win_count             saturating count of opened windows
module quad_and_gate_ctrl #(
  parameter int WIN_W       = 8,
  parameter int HOLD_W      = 8,
  parameter int CNT_W       = 16,
  parameter int DEF_WINDOW  = 20,
  parameter int DEF_HOLDOFF = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_wr,
  input  logic [1:0]       i_cfg_addr,
  input  logic [15:0]      i_cfg_data,
  output logic             o_cfg_ack,
  input  logic             i_arm,
  input  logic             i_trig,
  input  logic [3:0]       i_and_in,
  output logic [3:0]       o_gate_out,
  output logic [3:0]       o_hit,
  output logic             o_hit_valid,
  output logic             o_busy,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_win_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_OPEN  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  logic [3:0]        r_mask;
  logic [WIN_W-1:0]  r_window;
  logic [HOLD_W-1:0] r_holdoff;
  logic              r_auto;
  logic [3:0]        r_mask_sh;
  logic [HOLD_W-1:0] r_hold_sh;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [3:0]        r_acc;
  logic [3:0]        r_gate;
  logic [3:0]        r_hit;
  logic              r_hv;
  logic              r_ack;
  logic [CNT_W-1:0]  r_wc;

  logic              w_disarm;
  logic [WIN_W-1:0]  w_win_m1;
  logic [3:0]        w_acc_next;
  state_t            w_rearm;
  logic              w_unused;

  assign w_disarm   = i_cfg_wr && (i_cfg_addr == 2'd3) && i_cfg_data[1];
  // A zero-length window still opens for one cycle.
  assign w_win_m1   = (r_window == '0) ? '0 : r_window - WIN_W'(1);
  assign w_acc_next = r_acc | (i_and_in & r_mask_sh);
  assign w_rearm    = r_auto ? S_ARMED : S_IDLE;
  assign w_unused   = &{1'b0, i_cfg_data[15:8]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_mask     <= 4'hF;
      r_window   <= WIN_W'(DEF_WINDOW);
      r_holdoff  <= HOLD_W'(DEF_HOLDOFF);
      r_auto     <= 1'b0;
      r_mask_sh  <= 4'h0;
      r_hold_sh  <= '0;
      r_win_cnt  <= '0;
      r_hold_cnt <= '0;
      r_acc      <= 4'h0;
      r_gate     <= 4'h0;
      r_hit      <= 4'h0;
      r_hv       <= 1'b0;
      r_ack      <= 1'b0;
      r_wc       <= '0;
    end else begin
      r_ack <= i_cfg_wr;
      r_hv  <= 1'b0;
      if (i_cfg_wr) begin
        unique case (i_cfg_addr)
          2'd0: r_mask    <= i_cfg_data[3:0];
          2'd1: r_window  <= i_cfg_data[WIN_W-1:0];
          2'd2: r_holdoff <= i_cfg_data[HOLD_W-1:0];
          2'd3: r_auto    <= i_cfg_data[0];
        endcase
      end
      if (w_disarm) begin
        r_state <= S_IDLE;
        r_gate  <= 4'h0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_arm) r_state <= S_ARMED;
          end
          S_ARMED: begin
            if (i_trig) begin
              r_state   <= S_OPEN;
              r_gate    <= r_mask;
              r_mask_sh <= r_mask;
              r_hold_sh <= r_holdoff;
              r_win_cnt <= w_win_m1;
              r_acc     <= 4'h0;
              if (r_wc != '1) r_wc <= r_wc + CNT_W'(1);
            end
          end
          S_OPEN: begin
            r_acc <= w_acc_next;
            if (r_win_cnt == '0) begin
              // Last open cycle: its sample is folded into HIT.
              r_gate <= 4'h0;
              r_hit  <= w_acc_next;
              r_hv   <= 1'b1;
              if (r_hold_sh == '0) begin
                r_state <= w_rearm;
              end else begin
                r_state    <= S_HOLD;
                r_hold_cnt <= r_hold_sh - HOLD_W'(1);
              end
            end else begin
              r_win_cnt <= r_win_cnt - WIN_W'(1);
            end
          end
          S_HOLD: begin
            if (r_hold_cnt == '0) r_state <= w_rearm;
            else r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        endcase
      end
    end
  end

  assign o_state     = r_state;
  assign o_busy      = (r_state == S_OPEN) || (r_state == S_HOLD);
  assign o_gate_out  = r_gate;
  assign o_hit       = r_hit;
  assign o_hit_valid = r_hv;
  assign o_cfg_ack   = r_ack;
  assign o_win_count = r_wc;

endmodule

// File: tb/tb_quad_and_gate_ctrl.sv
// tb_quad_and_gate_ctrl: directed bench for quad_and_gate_ctrl.
// Second instance uses a 2-bit window counter for saturation.
module tb_quad_and_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_ack;
  logic        arm, trig;
  logic [3:0]  and_in;
  logic [3:0]  gate, hit;
  logic        hv, busy;
  logic [1:0]  state;
  logic [15:0] wc;

  logic        arm2, trig2;
  logic        ack2, hv2, busy2;
  logic [3:0]  gate2, hit2;
  logic [1:0]  state2, wc2;
  logic        z_wr;
  logic [1:0]  z_addr;
  logic [15:0] z_data;
  logic [3:0]  z_and;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  quad_and_gate_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_wr(cfg_wr), .i_cfg_addr(cfg_addr),
    .i_cfg_data(cfg_data), .o_cfg_ack(cfg_ack),
    .i_arm(arm), .i_trig(trig), .i_and_in(and_in),
    .o_gate_out(gate), .o_hit(hit),
    .o_hit_valid(hv), .o_busy(busy),
    .o_state(state), .o_win_count(wc)
  );

  quad_and_gate_ctrl #(
    .CNT_W(2), .DEF_WINDOW(1), .DEF_HOLDOFF(1)
  ) dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_wr(z_wr), .i_cfg_addr(z_addr),
    .i_cfg_data(z_data), .o_cfg_ack(ack2),
    .i_arm(arm2), .i_trig(trig2), .i_and_in(z_and),
    .o_gate_out(gate2), .o_hit(hit2),
    .o_hit_valid(hv2), .o_busy(busy2),
    .o_state(state2), .o_win_count(wc2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [15:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic arm_it();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Fire TRIG from ARMED and walk the window until IDLE/ARMED again.
  task automatic do_window(
    input  int          wr_at,
    input  logic [1:0]  wa,
    input  logic [15:0] wd,
    input  int          pulse_at,
    input  logic [3:0]  pv,
    input  logic [3:0]  mask,
    output int          n_open,
    output int          n_hold,
    output int          n_hv,
    output logic        gate_ok
  );
    logic done;
    n_open = 0; n_hold = 0; n_hv = 0;
    gate_ok = 1'b1; done = 1'b0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (hv) n_hv++;
      if (state == 2'd2) begin
        n_open++;
        if (gate !== mask) gate_ok = 1'b0;
      end else if (state == 2'd3) begin
        n_hold++;
        if (gate !== 4'h0) gate_ok = 1'b0;
      end else begin
        done = 1'b1;
        break;
      end
      cfg_wr   = (i == wr_at);
      cfg_addr = wa;
      cfg_data = wd;
      and_in   = (i == pulse_at) ? pv : 4'h0;
      tick();
    end
    cfg_wr = 1'b0;
    and_in = 4'h0;
    if (!done) chk("win_timeout", 32'd0, 32'd1);
  endtask

  int   no, nh, nv;
  logic gok;
  int   starts[2];
  int   ns;
  logic [1:0] prev;
  logic [15:0] wc0;

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    arm = 1'b0; trig = 1'b0; and_in = '0;
    arm2 = 1'b0; trig2 = 1'b0;
    z_wr = 1'b0; z_addr = '0; z_data = '0; z_and = '0;
    tick(); tick();
    chk("rst_gate", gate, 4'h0);
    chk("rst_state", state, 2'd0);
    chk("rst_hit", hit, 4'h0);
    chk("rst_hv", hv, 1'b0);
    chk("rst_ack", cfg_ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wc", wc, 16'd0);
    rst = 1'b0;
    tick();

    // Defaults: ARM@0, TRIG@2 -> open 3..22, holdoff 23..32, idle 33
    arm = 1'b1; tick(); arm = 1'b0;
    chk("a_armed", state, 2'd1);
    tick();
    trig = 1'b1; tick(); trig = 1'b0;
    chk("a_gate3", gate, 4'hF);
    chk("a_open3", state, 2'd2);
    chk("a_busy3", busy, 1'b1);
    chk("a_wc", wc, 16'd1);
    repeat (19) tick();
    chk("a_gate22", gate, 4'hF);
    tick();
    chk("a_gate23", gate, 4'h0);
    chk("a_hold23", state, 2'd3);
    chk("a_hv23", hv, 1'b1);
    chk("a_hit23", hit, 4'h0);
    tick();
    chk("a_hv24", hv, 1'b0);
    repeat (8) tick();
    chk("a_hold32", state, 2'd3);
    tick();
    chk("a_idle33", state, 2'd0);
    chk("a_busy33", busy, 1'b0);

    // Hits with MASK=0101
    cfg(2'd0, 16'h0005);
    chk("ack_hi", cfg_ack, 1'b1);
    tick();
    chk("ack_lo", cfg_ack, 1'b0);
    arm_it();
    do_window(-1, 2'd0, 16'd0, 5, 4'b0111, 4'h5, no, nh, nv, gok);
    chk("b_open", no, 20);
    chk("b_hold", nh, 10);
    chk("b_hv", nv, 1);
    chk("b_gate", gok, 1'b1);
    chk("b_hit", hit, 4'b0101);
    tick();
    chk("b_hit_hold", hit, 4'b0101);

    // WINDOW=0 -> one cycle
    cfg(2'd1, 16'd0);
    arm_it();
    do_window(-1, 2'd0, 16'd0, -1, 4'h0, 4'h5, no, nh, nv, gok);
    chk("c_open1", no, 1);
    chk("c_hold10", nh, 10);
    chk("c_hit0", hit, 4'h0);
    // HOLDOFF=0 -> straight to IDLE
    cfg(2'd2, 16'd0);
    arm_it();
    do_window(-1, 2'd0, 16'd0, -1, 4'h0, 4'h5, no, nh, nv, gok);
    chk("c2_open", no, 1);
    chk("c2_hold", nh, 0);
    chk("c2_hv", nv, 1);
    chk("c2_idle", state, 2'd0);

    // ARM+TRIG together -> ARMED, no window
    arm = 1'b1; trig = 1'b1; tick(); arm = 1'b0; trig = 1'b0;
    chk("d_armed", state, 2'd1);
    tick();
    chk("d_still", state, 2'd1);
    chk("d_gate", gate, 4'h0);
    cfg(2'd3, 16'h0002);
    chk("d_disarm", state, 2'd0);

    // Mid-window WINDOW write does not shorten current window
    cfg(2'd1, 16'd20);
    cfg(2'd2, 16'd3);
    arm_it();
    do_window(2, 2'd1, 16'd5, -1, 4'h0, 4'h5, no, nh, nv, gok);
    chk("e_open20", no, 20);
    chk("e_hold3", nh, 3);
    arm_it();
    do_window(-1, 2'd0, 16'd0, -1, 4'h0, 4'h5, no, nh, nv, gok);
    chk("e_open5", no, 5);

    // AUTO_REARM with TRIG held: windows 3, holdoff 2
    cfg(2'd1, 16'd3);
    cfg(2'd2, 16'd2);
    cfg(2'd3, 16'h0001);
    arm_it();
    wc0 = wc;
    trig = 1'b1;
    ns = 0;
    prev = state;
    for (int i = 0; i < 60; i++) begin
      if (state == 2'd2 && prev != 2'd2) begin
        starts[ns] = i;
        ns++;
        if (ns == 2) break;
      end
      prev = state;
      tick();
    end
    chk("f_starts", ns, 2);
    chk("f_gap", starts[1] - starts[0], 6);
    chk("f_wc", wc, wc0 + 16'd2);
    // DISARM while OPEN
    cfg(2'd3, 16'h0002);
    chk("f_dis_state", state, 2'd0);
    chk("f_dis_gate", gate, 4'h0);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      if (hv) nv++;
      tick();
    end
    chk("f_dis_hv", nv, 0);
    chk("f_dis_idle", state, 2'd0);
    trig = 1'b0;

    // Saturating 2-bit counter over 5 windows
    for (int k = 0; k < 5; k++) begin
      arm2 = 1'b1; tick(); arm2 = 1'b0;
      trig2 = 1'b1; tick(); trig2 = 1'b0;
      repeat (3) tick();
      if (k == 1) chk("g_wc2", wc2, 2'd2);
    end
    chk("g_wc_sat", wc2, 2'd3);

    // RESET inside a window drops the gate at once
    arm_it();
    trig = 1'b1; tick(); trig = 1'b0;
    chk("h_open_gate", gate, 4'h5);
    #2 rst = 1'b1;
    #1;
    chk("h_rst_gate", gate, 4'h0);
    chk("h_rst_state", state, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
